score_bcd_scheduler: RTL and testbench

Shares one combinational binary-to-BCD converter between the two player score registers of the Pong datapath. Per-player requests and a periodic auto-refresh are sequenced through the converter in round-robin order. Each result is captured into a per-player registered BCD score that drives the seven-segment display logic. The converter sits outside this block; this block drives its 8-bit input and samples its 12-bit output.

---
 rtl/score_pkg.sv | 27 ++
 rtl/refresh_timer.sv | 39 +++
 rtl/score_bcd_scheduler.sv | 114 +++++++++++
 tb/tb_score_bcd_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the Pong score BCD scheduler.
package score_pkg;

    localparam int BIN_W = 8;
    localparam int BCD_W = 12;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    // A converter result is only trustworthy if every nibble is a decimal digit.
    function automatic logic bcd_has_bad_nibble(input logic [BCD_W-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/refresh_timer.sv
// Free-running wrap counter that emits a one-cycle tick every REFRESH_CYCLES clocks.
module refresh_timer #(
    parameter int unsigned REFRESH_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam bit          ENABLED = (REFRESH_CYCLES != 0);
    localparam logic [CNT_W-1:0] LAST =
        ENABLED ? CNT_W'(REFRESH_CYCLES - 1) : '0;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    assign wrap = (cnt_q == LAST);

    // A disabled timer keeps its counter parked at zero and never ticks.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!ENABLED || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = ENABLED && wrap;

endmodule

// File: rtl/score_bcd_scheduler.sv
// Time-shares one external binary-to-BCD converter between both player scores,
// serving requests and periodic refreshes in round-robin order.
module score_bcd_scheduler
    import score_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [BIN_W-1:0] score_p1,
    input  logic [BIN_W-1:0] score_p2,
    output logic [BIN_W-1:0] conv_bin,
    input  logic [BCD_W-1:0] conv_bcd,
    output logic [BCD_W-1:0] bcd_p1,
    output logic [BCD_W-1:0] bcd_p2,
    output logic [1:0]       done,
    output logic             busy,
    output logic             bcd_err
);

    logic tick;

    refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    state_t           state_q;
    logic [1:0]       pending_q;
    logic [1:0]       pending_d;
    logic [1:0]       clear;
    logic             rr_ptr_q;
    logic             grant_q;
    logic             pick;
    logic [BIN_W-1:0] conv_bin_q;
    logic [BCD_W-1:0] bcd_p1_q;
    logic [BCD_W-1:0] bcd_p2_q;
    logic [1:0]       done_q;
    logic             busy_q;
    logic             bcd_err_q;

    // A fresh request on the capture edge wins over the clear, so the player is re-served.
    always_comb begin
        clear = 2'b00;
        if (state_q == CONVERT) begin
            clear[grant_q] = 1'b1;
        end
        pending_d = (pending_q & ~clear) | req | {2{tick}};

        pick = P1;
        if (pending_q == 2'b11) begin
            pick = rr_ptr_q;
        end else if (pending_q[P2]) begin
            pick = P2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= 2'b00;
            rr_ptr_q   <= P1;
            grant_q    <= P1;
            conv_bin_q <= '0;
            bcd_p1_q   <= '0;
            bcd_p2_q   <= '0;
            done_q     <= 2'b00;
            busy_q     <= 1'b0;
            bcd_err_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            done_q    <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (|pending_q) begin
                        grant_q    <= pick;
                        conv_bin_q <= (pick == P2) ? score_p2 : score_p1;
                        busy_q     <= 1'b1;
                        state_q    <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (grant_q == P2) begin
                        bcd_p2_q <= conv_bcd;
                    end else begin
                        bcd_p1_q <= conv_bcd;
                    end
                    done_q[grant_q] <= 1'b1;
                    rr_ptr_q        <= ~grant_q;
                    if (bcd_has_bad_nibble(conv_bcd)) begin
                        bcd_err_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign conv_bin = conv_bin_q;
    assign bcd_p1   = bcd_p1_q;
    assign bcd_p2   = bcd_p2_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign bcd_err  = bcd_err_q;

endmodule

// File: tb/tb_score_bcd_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model,
// and a second instance exercising the periodic auto-refresh.
module tb_score_bcd_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, auto-refresh disabled
    logic        rst;
    logic [1:0]  req;
    logic [7:0]  score_p1;
    logic [7:0]  score_p2;
    logic [7:0]  conv_bin;
    logic [11:0] conv_bcd;
    logic [11:0] bcd_p1;
    logic [11:0] bcd_p2;
    logic [1:0]  done;
    logic        busy;
    logic        bcd_err;
    logic        inject;

    // Refresh instance, 16-cycle period
    logic        rst_r;
    logic [1:0]  req_r;
    logic [7:0]  score_r1;
    logic [7:0]  score_r2;
    logic [7:0]  conv_bin_r;
    logic [11:0] conv_bcd_r;
    logic [11:0] bcd_p1_r;
    logic [11:0] bcd_p2_r;
    logic [1:0]  done_r;
    logic        busy_r;
    logic        bcd_err_r;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    assign conv_bcd   = inject ? 12'h0A0 : to_bcd(int'(conv_bin));
    assign conv_bcd_r = to_bcd(int'(conv_bin_r));

    score_bcd_scheduler #(.REFRESH_CYCLES(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .score_p1 (score_p1),
        .score_p2 (score_p2),
        .conv_bin (conv_bin),
        .conv_bcd (conv_bcd),
        .bcd_p1   (bcd_p1),
        .bcd_p2   (bcd_p2),
        .done     (done),
        .busy     (busy),
        .bcd_err  (bcd_err)
    );

    score_bcd_scheduler #(.REFRESH_CYCLES(16)) dut_rf (
        .clk      (clk),
        .rst      (rst_r),
        .req      (req_r),
        .score_p1 (score_r1),
        .score_p2 (score_r2),
        .conv_bin (conv_bin_r),
        .conv_bcd (conv_bcd_r),
        .bcd_p1   (bcd_p1_r),
        .bcd_p2   (bcd_p2_r),
        .done     (done_r),
        .busy     (busy_r),
        .bcd_err  (bcd_err_r)
    );

    // Behavioural model of the main instance
    logic [1:0]  m_pend;
    logic        m_conv;
    logic        m_grant;
    logic        m_rr;
    logic [7:0]  m_bin;
    logic [11:0] m_bcd1;
    logic [11:0] m_bcd2;
    logic [1:0]  m_done;
    logic        m_err;

    task automatic model_reset();
        m_pend = 2'b00; m_conv = 1'b0; m_grant = 1'b0; m_rr = 1'b0;
        m_bin = 8'd0; m_bcd1 = 12'd0; m_bcd2 = 12'd0; m_done = 2'b00; m_err = 1'b0;
    endtask

    task automatic model_edge();
        logic [1:0]  clr;
        logic [11:0] res;
        clr = 2'b00;
        if (m_conv) begin
            res = inject ? 12'h0A0 : to_bcd(int'(m_bin));
            if (m_grant) m_bcd2 = res; else m_bcd1 = res;
            m_done = m_grant ? 2'b10 : 2'b01;
            clr    = m_done;
            m_rr   = !m_grant;
            if (res[11:8] > 9 || res[7:4] > 9 || res[3:0] > 9) m_err = 1'b1;
            m_conv = 1'b0;
        end else begin
            m_done = 2'b00;
            if (m_pend != 2'b00) begin
                m_grant = (m_pend == 2'b11) ? m_rr : m_pend[1];
                m_bin   = m_grant ? score_p2 : score_p1;
                m_conv  = 1'b1;
            end
        end
        m_pend = (m_pend & ~clr) | req;
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("conv_bin", 12'(conv_bin), 12'(m_bin));
        check("bcd_p1",   bcd_p1,        m_bcd1);
        check("bcd_p2",   bcd_p2,        m_bcd2);
        check("done",     12'(done),     12'(m_done));
        check("busy",     12'(busy),     12'(m_conv));
        check("bcd_err",  12'(bcd_err),  12'(m_err));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Called at a negedge: asynchronous clear must be visible immediately.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_done;
        rst = 1'b1; req = 2'b00; score_p1 = 8'd0; score_p2 = 8'd0; inject = 1'b0;
        rst_r = 1'b1; req_r = 2'b00; score_r1 = 8'd3; score_r2 = 8'd99;
        model_reset();
        @(negedge clk);
        do_reset();
        repeat (5) cycle();

        // Reset in the middle of activity, then a long idle stretch
        score_p1 = 8'd42; req = 2'b01;
        cycle();
        req = 2'b00;
        do_reset();
        repeat (10) cycle();

        // Single P1 request
        score_p1 = 8'd200; req = 2'b01;
        cycle();
        req = 2'b00;
        repeat (4) cycle();
        check("single_p1", bcd_p1, 12'h200);
        check("single_p2_held", bcd_p2, 12'h000);

        // Simultaneous requests from reset
        do_reset();
        score_p1 = 8'd57; score_p2 = 8'd255; req = 2'b11;
        cycle();
        req = 2'b00;
        repeat (6) cycle();
        check("simul_p1", bcd_p1, 12'h057);
        check("simul_p2", bcd_p2, 12'h255);

        // Re-request of P2 on its own capture edge with a new score
        score_p2 = 8'd9; req = 2'b10;
        cycle();
        req = 2'b00;
        cycle();
        req = 2'b10; score_p2 = 8'd10;
        cycle();
        req = 2'b00;
        repeat (4) cycle();
        check("rereq_p2", bcd_p2, 12'h010);

        // Illegal converter output sets a sticky error
        inject = 1'b1; req = 2'b01;
        cycle();
        req = 2'b00;
        repeat (3) cycle();
        inject = 1'b0;
        check("err_set", 12'(bcd_err), 12'h001);
        score_p1 = 8'd5; req = 2'b01;
        cycle();
        req = 2'b00;
        repeat (3) cycle();
        check("err_sticky", 12'(bcd_err), 12'h001);

        // Reset while CONVERT is in progress aborts it
        score_p1 = 8'd77; req = 2'b01;
        cycle();
        req = 2'b00;
        cycle();
        check("abort_busy", 12'(busy), 12'h001);
        do_reset();
        repeat (3) cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            req      = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            score_p1 = 8'($urandom);
            score_p2 = 8'($urandom);
            cycle();
        end
        req = 2'b00;
        repeat (4) cycle();

        // Auto-refresh instance: tick on every 16th edge, P1 captured 2 edges later, P2 4 edges later
        @(negedge clk);
        rst_r = 1'b0;
        for (int k = 1; k <= 52; k++) begin
            @(negedge clk);
            exp_done = 2'b00;
            if (k >= 16 && (k - 2) % 16 == 0) exp_done = 2'b01;
            if (k >= 16 && (k - 4) % 16 == 0) exp_done = 2'b10;
            check($sformatf("refresh_done_e%0d", k), 12'(done_r), 12'(exp_done));
        end
        check("refresh_p1", bcd_p1_r, 12'h003);
        check("refresh_p2", bcd_p2_r, 12'h099);
        check("refresh_err", 12'(bcd_err_r), 12'h000);
        check("refresh_busy", 12'(busy_r), 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
